// File: rtl/ram_copier.sv
// ram_copier: copies len words inside a single-port RAM, from src upward to dst
// upward, one word every two cycles (a read cycle followed by a write cycle).
//
// Parameters
//   BUS_WIDTH      RAM data word width
//   ADDRESS_WIDTH  RAM address width (2^ADDRESS_WIDTH words)
//
// Ports
//   clk    clock; all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   start  copy request, sampled only while idle
//   src    first source address       (captured on accepted start)
//   dst    first destination address  (captured on accepted start)
//   len    number of words to copy     (captured on accepted start)
//   ad     RAM address
//   st     RAM write strobe
//   X      RAM write data
//   O      RAM read data, combinationally valid for the current ad
//   busy   high whenever the block is not idle
//   done   one-cycle completion pulse
//
// Handshake: start is a request with busy acting as its inverted ready. A copy
// is accepted on any rising edge where start=1 and busy=0; while busy=1, start
// and the src/dst/len inputs are ignored. done pulses for one cycle at the end
// of every accepted request, including a zero-length one.
//
// Every output is decoded from registered state only, so no input reaches an
// output combinationally. The current FSM state is visible on the internal
// signal 'state' for checkers to bind to.
module ram_copier #(
  parameter int BUS_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] src,
  input  logic [ADDRESS_WIDTH-1:0] dst,
  input  logic [ADDRESS_WIDTH-1:0] len,
  output logic [ADDRESS_WIDTH-1:0] ad,
  output logic                     st,
  output logic [BUS_WIDTH-1:0]     X,
  input  logic [BUS_WIDTH-1:0]     O,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDRESS_WIDTH-1:0] src_ptr;
  logic [ADDRESS_WIDTH-1:0] dst_ptr;
  logic [ADDRESS_WIDTH-1:0] cnt;
  logic [ADDRESS_WIDTH-1:0] len_q;
  logic [BUS_WIDTH-1:0]     data_q;
  logic [ADDRESS_WIDTH-1:0] cnt_inc;
  logic                     last_word;

  assign cnt_inc   = cnt + ONE;
  // Decided in WR from the post-increment count, so the final write goes
  // straight to FIN instead of an extra read.
  assign last_word = (cnt_inc == len_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? FIN : RD;
        end
      end
      RD:      state_nxt = WR;
      WR:      state_nxt = last_word ? FIN : RD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: pointers, counter, captured length and the read-data holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            src_ptr <= src;
            dst_ptr <= dst;
            len_q   <= len;
            cnt     <= '0;
          end
        end
        RD: begin
          data_q <= O;
        end
        WR: begin
          // Pointers wrap naturally modulo 2^ADDRESS_WIDTH.
          src_ptr <= src_ptr + ONE;
          dst_ptr <= dst_ptr + ONE;
          cnt     <= cnt_inc;
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode (registers only)
  always_comb begin
    ad = '0;
    case (state)
      RD:      ad = src_ptr;
      WR:      ad = dst_ptr;
      default: ad = '0;
    endcase
  end

  assign st   = (state == WR);
  assign X    = data_q;
  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule

// File: tb/tb_ram_copier.sv
// tb_ram_copier: directed bench for ram_copier with a behavioural RAM model,
// per-copy counters of busy cycles, write strobes and done pulses, and a
// single checking task feeding the end-of-test summary.
module tb_ram_copier;

  localparam int BW = 8;
  localparam int AW = 8;

  // Clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] len;
  logic [AW-1:0] ad;
  logic          st;
  logic [BW-1:0] X;
  logic [BW-1:0] O;
  logic          busy;
  logic          done;

  ram_copier #(.BUS_WIDTH(BW), .ADDRESS_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .src   (src),
    .dst   (dst),
    .len   (len),
    .ad    (ad),
    .st    (st),
    .X     (X),
    .O     (O),
    .busy  (busy),
    .done  (done)
  );

  // RAM model: combinational read, write on rising edge when st=1.
  // A preload port lets the bench fill words while the DUT is idle.
  logic [BW-1:0] mem [256];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [BW-1:0] pl_data;

  assign O = mem[ad];

  always @(posedge clk) begin
    if (st) begin
      mem[ad] <= X;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  // Activity counters, sampled at the rising edge that ends each cycle
  logic cnt_clr;
  int   busy_cycles;
  int   st_pulses;
  int   done_pulses;

  always @(posedge clk) begin
    if (cnt_clr) begin
      busy_cycles <= 0;
      st_pulses   <= 0;
      done_pulses <= 0;
    end else begin
      if (busy) busy_cycles <= busy_cycles + 1;
      if (st)   st_pulses   <= st_pulses + 1;
      if (done) done_pulses <= done_pulses + 1;
    end
  end

  // Scoreboard bookkeeping
  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic preload(input logic [AW-1:0] a, input logic [BW-1:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Clears the counters, then holds start for exactly one rising edge.
  // Returns at the negedge following the accepting edge.
  task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] n);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    src   = s;
    dst   = d;
    len   = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done at a negedge, then lets the FIN cycle close.
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k = k + 1;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    src      = '0;
    dst      = '0;
    len      = '0;
    pl_en    = 1'b0;
    pl_addr  = '0;
    pl_data  = '0;
    cnt_clr  = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    #3;
    check("rst_ad",   32'(ad),   32'd0);
    check("rst_st",   32'(st),   32'd0);
    check("rst_X",    32'(X),    32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Preload with reset still asserted (DUT write strobe is held low)
    @(negedge clk); cnt_clr = 1'b0;
    preload(8'h10, 8'hA1);
    preload(8'h11, 8'hB2);
    preload(8'h12, 8'hC3);
    preload(8'h13, 8'hD4);

    // Release reset and request on the very first edge with rst_n=1
    @(negedge clk);
    rst_n = 1'b1;
    src   = 8'h10;
    dst   = 8'h40;
    len   = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_edge_busy", 32'(busy), 32'd1);
    check("rd0_ad", 32'(ad), 32'h10);
    check("rd0_st", 32'(st), 32'd0);
    @(negedge clk);
    check("wr0_ad", 32'(ad), 32'h40);
    check("wr0_st", 32'(st), 32'd1);
    check("wr0_X",  32'(X),  32'hA1);
    wait_done("copy");
    check("copy_idle", 32'(busy), 32'd0);
    check("copy_ad_idle", 32'(ad), 32'd0);
    check("copy_m40", 32'(mem[8'h40]), 32'hA1);
    check("copy_m41", 32'(mem[8'h41]), 32'hB2);
    check("copy_m42", 32'(mem[8'h42]), 32'hC3);
    check("copy_m43", 32'(mem[8'h43]), 32'hD4);

    // Full copy with counter accounting
    launch(8'h10, 8'h48, 8'd4);
    wait_done("copy2");
    check("copy2_busy_cycles", 32'(busy_cycles), 32'd9);
    check("copy2_st_pulses",   32'(st_pulses),   32'd4);
    check("copy2_done_pulses", 32'(done_pulses), 32'd1);
    check("copy2_m4b", 32'(mem[8'h4B]), 32'hD4);

    // Zero length: FIN immediately, no RAM access
    preload(8'h80, 8'h55);
    launch(8'h40, 8'h80, 8'd0);
    check("zero_done_next", 32'(done), 32'd1);
    check("zero_st", 32'(st), 32'd0);
    wait_done("zero");
    check("zero_busy_cycles", 32'(busy_cycles), 32'd1);
    check("zero_st_pulses",   32'(st_pulses),   32'd0);
    check("zero_done_pulses", 32'(done_pulses), 32'd1);
    check("zero_m80", 32'(mem[8'h80]), 32'h55);

    // Address wrap on the source pointer
    preload(8'hFE, 8'h11);
    preload(8'hFF, 8'h22);
    preload(8'h00, 8'h33);
    launch(8'hFE, 8'h02, 8'd3);
    wait_done("wrap");
    check("wrap_m02", 32'(mem[8'h02]), 32'h11);
    check("wrap_m03", 32'(mem[8'h03]), 32'h22);
    check("wrap_m04", 32'(mem[8'h04]), 32'h33);
    check("wrap_busy_cycles", 32'(busy_cycles), 32'd7);

    // Address wrap on the destination pointer
    launch(8'h40, 8'hFF, 8'd2);
    wait_done("dwrap");
    check("dwrap_mff", 32'(mem[8'hFF]), 32'hA1);
    check("dwrap_m00", 32'(mem[8'h00]), 32'hB2);

    // Forward overlap
    preload(8'h00, 8'h01);
    preload(8'h01, 8'h02);
    preload(8'h02, 8'h03);
    preload(8'h03, 8'h04);
    launch(8'h00, 8'h01, 8'd3);
    wait_done("ovl");
    check("ovl_m00", 32'(mem[8'h00]), 32'h01);
    check("ovl_m01", 32'(mem[8'h01]), 32'h01);
    check("ovl_m02", 32'(mem[8'h02]), 32'h01);
    check("ovl_m03", 32'(mem[8'h03]), 32'h01);

    // Busy-ignore: second request with new operands mid-copy
    preload(8'h20, 8'h9A);
    preload(8'h21, 8'h9B);
    preload(8'h22, 8'h9C);
    preload(8'h70, 8'hEE);
    launch(8'h20, 8'h60, 8'd3);
    @(negedge clk);
    src   = 8'h30;
    dst   = 8'h70;
    len   = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src   = 8'h31;
    dst   = 8'h71;
    wait_done("ign");
    check("ign_m60", 32'(mem[8'h60]), 32'h9A);
    check("ign_m61", 32'(mem[8'h61]), 32'h9B);
    check("ign_m62", 32'(mem[8'h62]), 32'h9C);
    check("ign_m70", 32'(mem[8'h70]), 32'hEE);
    check("ign_busy_cycles", 32'(busy_cycles), 32'd7);
    check("ign_st_pulses",   32'(st_pulses),   32'd3);
    check("ign_done_pulses", 32'(done_pulses), 32'd1);

    // Reset during the second WR of a len=4 copy
    preload(8'h50, 8'hE0);
    preload(8'h51, 8'hE1);
    preload(8'h52, 8'hE2);
    preload(8'h53, 8'hE3);
    launch(8'h50, 8'h58, 8'd4);   // now in RD0
    @(negedge clk);               // WR0
    @(negedge clk);               // RD1
    @(negedge clk);               // WR1
    check("rst_mid_st_before", 32'(st), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_st",   32'(st),   32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_X",    32'(X),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_m58", 32'(mem[8'h58]), 32'hE0);
    check("rst_mid_m59", 32'(mem[8'h59]), 32'h00);
    check("rst_mid_m5a", 32'(mem[8'h5A]), 32'h00);
    check("rst_mid_idle", 32'(busy), 32'd0);
    launch(8'h50, 8'h58, 8'd4);
    wait_done("post_rst");
    check("post_rst_m58", 32'(mem[8'h58]), 32'hE0);
    check("post_rst_m59", 32'(mem[8'h59]), 32'hE1);
    check("post_rst_m5a", 32'(mem[8'h5A]), 32'hE2);
    check("post_rst_m5b", 32'(mem[8'h5B]), 32'hE3);
    check("post_rst_st_pulses", 32'(st_pulses), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
